// File: rtl/configure.sv
// Shared types and constants for the bram port arbiter.
package configure;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 4;

  localparam int unsigned starve_max = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWNER_I,
    OWNER_D
  } arb_owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

endpackage

// File: rtl/arb_slot.sv
// One-deep pending request register; also presents the slot-or-incoming candidate.
module arb_slot
  import configure::*;
(
  input  logic clock,
  input  logic reset,
  input  logic set,
  input  req_t req,
  input  logic grant,
  output logic occupied,
  output logic cand_c,
  output req_t cand_req_c
);

  req_t held;

  // A granted candidate never lands in the slot, even if it arrived this cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occupied <= 1'b0;
      held     <= '0;
    end else if (grant) begin
      occupied <= 1'b0;
    end else if (set && !occupied) begin
      occupied <= 1'b1;
      held     <= req;
    end
  end

  assign cand_c     = occupied | set;
  assign cand_req_c = occupied ? held : req;

  a_no_overrun: assert property (@(posedge clock) disable iff (reset) !(set && occupied))
    else $error("arb_slot: request pulse into an occupied slot was dropped");

endmodule

// File: rtl/bram_arbiter.sv
// Shares the bram port between instruction fetch and data access:
// data priority, with an instruction grant forced after STARVE_MAX data grants.
module bram_arbiter
  import configure::*;
#(
  parameter int unsigned STARVE_MAX = starve_max
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              imem_valid,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_ready,
  input  logic              dmem_valid,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [STRB_W-1:0] dmem_wstrb,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_ready,
  output logic              bram_valid,
  output logic              bram_instr,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic [STRB_W-1:0] bram_wstrb,
  input  logic [DATA_W-1:0] bram_rdata,
  input  logic              bram_ready
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_t       state, state_nxt;
  arb_owner_t       owner, owner_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  req_t             bram_req, bram_req_nxt;
  logic             bram_valid_nxt, bram_instr_nxt;

  req_t i_req, d_req, i_cand, d_cand;
  logic i_cand_v, d_cand_v, i_occ, d_occ;
  logic grant, pick_i;

  assign i_req = '{addr: imem_addr, wdata: '0, wstrb: '0};
  assign d_req = '{addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb};

  arb_slot u_slot_i (
    .clock      (clock),
    .reset      (reset),
    .set        (imem_valid),
    .req        (i_req),
    .grant      (grant && pick_i),
    .occupied   (i_occ),
    .cand_c     (i_cand_v),
    .cand_req_c (i_cand)
  );

  arb_slot u_slot_d (
    .clock      (clock),
    .reset      (reset),
    .set        (dmem_valid),
    .req        (d_req),
    .grant      (grant && !pick_i),
    .occupied   (d_occ),
    .cand_c     (d_cand_v),
    .cand_req_c (d_cand)
  );

  // Next-state, grant selection and starvation accounting.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    starve_nxt     = starve_cnt;
    bram_req_nxt   = bram_req;
    bram_valid_nxt = 1'b0;
    bram_instr_nxt = bram_instr;
    grant          = 1'b0;
    pick_i         = i_cand_v && (!d_cand_v || (starve_cnt == STARVE_LIM));

    case (state)
      IDLE:  grant = i_cand_v || d_cand_v;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (bram_ready) begin
          grant     = i_cand_v || d_cand_v;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (grant) begin
      state_nxt      = ISSUE;
      bram_valid_nxt = 1'b1;
      bram_instr_nxt = pick_i;
      owner_nxt      = pick_i ? OWNER_I : OWNER_D;
      bram_req_nxt   = pick_i ? i_cand : d_cand;
      if (pick_i) bram_req_nxt.wstrb = '0;
    end

    if (!i_cand_v || (grant && pick_i)) begin
      starve_nxt = '0;
    end else if (grant && (starve_cnt != STARVE_LIM)) begin
      starve_nxt = starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWNER_D;
      starve_cnt <= '0;
      bram_req   <= '0;
      bram_valid <= 1'b0;
      bram_instr <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
      bram_req   <= bram_req_nxt;
      bram_valid <= bram_valid_nxt;
      bram_instr <= bram_instr_nxt;
    end
  end

  assign bram_addr  = bram_req.addr;
  assign bram_wdata = bram_req.wdata;
  assign bram_wstrb = bram_req.wstrb;

  // Completion is steered combinationally so rdata and ready share a cycle.
  assign imem_ready = bram_ready && (state == WAIT) && (owner == OWNER_I);
  assign dmem_ready = bram_ready && (state == WAIT) && (owner == OWNER_D);
  assign imem_rdata = bram_rdata;
  assign dmem_rdata = bram_rdata;

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Shares the single testbench/on-chip `bram` port between the core's instruction-fetch and data-access requesters. Each requester issues single-cycle valid pulses with a one-outstanding-request protocol. The arbiter latches requests, grants one at a time with data priority plus an anti-starvation guard, drives `bram_instr`, and steers `bram_ready` back to the owning requester.

## Interface
- `STARVE_MAX`, default 4: max consecutive data grants while an instruction request is pending; range 1–15.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `clock`  in  1  single clock; all state on rising edge.
- `imem_valid`  in  1  one-cycle instruction request pulse.
- `imem_addr`  in  32  instruction byte address.
- `imem_rdata`  out  32  read data; equals `bram_rdata`.
- `imem_ready`  out  1  one-cycle completion for the instruction port.
- `dmem_valid`  in  1  one-cycle data request pulse.
- `dmem_addr`  in  32  data byte address.
- `dmem_wdata`  in  32  write data.
- `dmem_wstrb`  in  4  byte strobes; 0 means read.
- `dmem_rdata`  out  32  read data; equals `bram_rdata`.
- `dmem_ready`  out  1  one-cycle completion for the data port.
- `bram_valid`  out  1  registered, one-cycle access pulse.
- `bram_instr`  out  1  1 when the current grant is the instruction port.
- `bram_addr`, `bram_wdata`  out  32  registered request fields.
- `bram_wstrb`  out  4  registered; forced to 0 for instruction grants.
- `bram_rdata`  in  32  memory read data.
- `bram_ready`  in  1  memory completion.

## Operation
- One pending slot per port: {valid, addr, wdata, wstrb}. A slot is set on the port's valid pulse and cleared when the slot is granted.
- A requester must not pulse valid again before its ready. A pulse into an occupied slot is ignored. A simulation-only assertion flags it.
- The candidate set is the slot contents OR the same-cycle incoming pulse, so a request never waits an extra cycle to be latched.
- FSM states are IDLE, ISSUE and WAIT.
  - IDLE: if any candidate exists, grant it and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `bram_valid`=1 for exactly this cycle; go to WAIT unconditionally.
  - WAIT: hold until `bram_ready`=1. In that cycle, pulse the owner's ready. At the edge, if a candidate exists, grant it and go to ISSUE; otherwise go to IDLE.
- Grant rule:
  - Data wins over instruction.
  - Exception: if the instruction candidate is present and `starve_cnt` equals `STARVE_MAX`, the instruction port wins.
- `starve_cnt` (4 bits):
  - Increments on each data grant made while an instruction candidate is present.
  - Clears on any instruction grant, and when no instruction candidate is present.
  - Saturates at `STARVE_MAX`.
- On grant, the bram_* output registers load from the chosen source, and `owner` is registered as I or D.
- `bram_ready` arriving in IDLE or ISSUE is ignored; no requester ready is produced.
- `imem_ready` = `bram_ready` & WAIT & owner==I.
- `dmem_ready` = `bram_ready` & WAIT & owner==D.

## Timing
- Reset values:
  - FSM in IDLE; slots empty; `starve_cnt`=0; owner=D.
  - `bram_valid`=0, `bram_instr`=0, `bram_addr`/`bram_wdata`=0, `bram_wstrb`=0.
  - `imem_ready`=`dmem_ready`=0.
- Reset is asynchronous and may occur mid-access. Any in-flight access is dropped, and a late `bram_ready` after reset is ignored.
- Idle latency with a one-cycle-ready memory:
  - Pulse in cycle 0.
  - `bram_valid` in cycle 1.
  - `bram_ready` and port ready in cycle 2.
- Back-to-back throughput: one access per 2 cycles. The next `bram_valid` comes in the cycle after `bram_ready`.
- Port ready is combinational from `bram_ready`; rdata is valid in the same cycle as ready.
- Simultaneous pulses in cycle 0 with a one-cycle-ready memory:
  - Data is granted first: `bram_valid` in cycle 1, `dmem_ready` in cycle 2.
  - Instruction follows: `bram_valid` in cycle 3, `imem_ready` in cycle 4.

## Structure
- Package `configure` gains `arb_state_t` (IDLE/ISSUE/WAIT), `arb_owner_t` (I/D), and the `starve_max` default constant.
- One natural sub-module: `arb_slot`, the pending request register with set/clear/occupied logic. It is instantiated twice; the instruction instance ties wdata/wstrb to 0.

## Test plan
- Single instruction read:
  - Stimulus: `imem_valid` with addr 0x100 in cycle 0.
  - Required: `bram_valid`=1, `bram_instr`=1, `bram_addr`=0x100, `bram_wstrb`=0 in cycle 1.
  - Required: `imem_ready`=1 and `imem_rdata`=memory word in cycle 2; `dmem_ready` stays 0.
- Simultaneous pulses:
  - Stimulus: data write (addr 0x200, wdata 0xDEADBEEF, wstrb 0xF) and instruction fetch (addr 0x104) in the same cycle.
  - Required: data issued in cycle 1 with `bram_instr`=0; instruction issued in cycle 3; readback of 0x200 returns 0xDEADBEEF.
- Starvation guard:
  - Stimulus: instruction held pending while 6 data requests are issued back-to-back, `STARVE_MAX`=4.
  - Required: grant order D,D,D,D,I,D,D.
- Request during busy:
  - Stimulus: instruction pulse arriving in WAIT of a data access.
  - Required: it is latched and issued in the cycle after `dmem_ready`, with no request lost.
- Reset mid-access:
  - Stimulus: assert `reset` in ISSUE, then `bram_ready` after release.
  - Required: no port ready; slots empty; `bram_valid`=0.
- Stray ready:
  - Stimulus: `bram_ready` pulsed in IDLE.
  - Required: both port readies stay 0; state stays IDLE.
